// File: rtl/matmul_pkg.sv
// Shared matmul types and default widths for the output read-back path.
// Latency: n/a. Backpressure: n/a.
package matmul_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO with a per-entry last flag and occupancy count.
// Latency: push visible at head the next cycle. Backpressure: none; the caller guarantees space.
module drain_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_push_last,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_head_last,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (r_count != CW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= {i_push_last, i_push_dat};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_head_dat  = r_mem[r_rptr][WIDTH-1:0];
    assign o_head_last = r_mem[r_rptr][WIDTH];
    assign o_count     = r_count;

endmodule

// File: rtl/output_drain.sv
// Streams a block of output-memory words out over valid/ready; OUTPUT_DRAIN_RELU_EN clamps negative words to 0.
// Latency: 3 cycles from start to first beat, then 1 word/cycle. Backpressure: reads stall on FIFO credit.
module output_drain
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_dout,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

    drain_state_t          r_state;
    drain_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_issue_left;
    logic [ADDR_WIDTH:0]   r_beats_left;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_last_hs;
    logic                  w_credit_ok;
    logic                  w_accept;
    logic                  w_zero_start;
    logic [CW-1:0]         w_occ;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head_dat;
    logic                  w_head_last;
    logic [DATA_WIDTH-1:0] w_out_dat;

    drain_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_dat  (i_mem_dout),
        .i_push_last (r_inflight_last),
        .i_pop       (w_pop),
        .o_head_dat  (w_head_dat),
        .o_head_last (w_head_last),
        .o_empty     (w_empty),
        .o_count     (w_occ)
    );

    // Credit counts the read still in flight; a pop in the same cycle is deliberately not credited.
    assign w_credit_ok  = (w_occ + CW'(r_inflight)) < CW'(FIFO_DEPTH);
    assign w_pop        = o_m_valid && i_m_ready;
    assign w_last_hs    = w_pop && (r_beats_left == ONE);
    assign w_accept     = (r_state == IDLE) && i_start && (i_len != '0);
    assign w_zero_start = (r_state == IDLE) && i_start && (i_len == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_issue && (r_issue_left == ONE)) w_state_nxt = FLUSH;
            FLUSH:   if (w_last_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state != IDLE);
        w_issue = (r_state == RUN) && w_credit_ok;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr          <= '0;
            r_issue_left    <= '0;
            r_beats_left    <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= w_zero_start || ((r_state == FLUSH) && w_last_hs);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_left == ONE);
            if (w_accept) begin
                r_addr       <= i_base_addr;
                r_issue_left <= i_len;
                r_beats_left <= i_len;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_issue_left <= r_issue_left - ONE;
                end
                if (w_pop) begin
                    r_beats_left <= r_beats_left - ONE;
                end
            end
        end
    end

`ifdef OUTPUT_DRAIN_RELU_EN
    assign w_out_dat = w_head_dat[DATA_WIDTH-1] ? '0 : w_head_dat;
`else
    assign w_out_dat = w_head_dat;
`endif

    assign o_done     = r_done;
    assign o_mem_en   = w_issue;
    assign o_mem_we   = 1'b0;
    assign o_mem_addr = r_addr;
    assign o_m_valid  = !w_empty;
    assign o_m_data   = o_m_valid ? w_out_dat : '0;
    assign o_m_last   = o_m_valid && w_head_last;

endmodule

// File: doc/output_drain.md
# output_drain

Read-back stage downstream of the matmul output memory. On `start`, it issues sequential reads on one port of the output memory and streams the result words out over a valid/ready interface, with `m_last` on the final word and a `done` pulse after it. A small internal FIFO absorbs the memory's 1-cycle read latency, so the stream runs at one word per cycle whenever `m_ready` is held high.

## Interface
- `DATA_WIDTH`, 16: result word width; must match the output memory.
- `ADDR_WIDTH`, 12: output memory address width (64×64 = 4096 words).
- `FIFO_DEPTH`, 4: depth of the internal read-data FIFO; power of two, at least 2.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: launch a transfer; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH: first word address; captured on `start`.
- `len`  in  ADDR_WIDTH+1: word count, 0..4096; captured on `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`  out  1: one-cycle completion pulse.
- `mem_en`  out  1: memory chip enable, one read per asserted cycle.
- `mem_we`  out  1: tied to 0.
- `mem_addr`  out  ADDR_WIDTH: read address.
- `mem_dout`  in  DATA_WIDTH: memory read data, valid 1 cycle after `mem_en`.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: downstream ready.
- `m_data`  out  DATA_WIDTH: stream word.
- `m_last`  out  1: marks the final word of the transfer.

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN when `start` is high and `len` ≠ 0.
  - IDLE with `start` and `len` = 0: `done` pulses the next cycle. No reads and no beats occur, and the FSM stays in IDLE.
  - RUN → FLUSH after the cycle that issues the last read.
  - FLUSH → IDLE on the handshake of the `m_last` beat; `done` pulses the following cycle.
- Read address for read i (0-based) is `(base_addr + i) mod 2^ADDR_WIDTH`. Addresses wrap with no error.
- Read issue rule: in RUN, `mem_en` = 1 when `occupancy + inflight < FIFO_DEPTH`.
  - Both counts are evaluated at the start of the cycle; a same-cycle pop is not credited.
  - `inflight` is 1 if a read was issued in the previous cycle, otherwise 0.
  - The FIFO therefore never overflows and no read data is ever dropped.
- `mem_dout` is written into the FIFO in the cycle after its `mem_en`. This is independent of `m_ready`.
- Stream side:
  - `m_valid` = FIFO not empty; `m_data` = FIFO head.
  - A beat transfers when `m_valid & m_ready`.
  - Word order equals address order.
- `m_last` is high together with the head word when that word is the final one of the transfer. A remaining-beat counter is decremented on each handshake.
- `start` while `busy` is ignored and has no side effects.
- Reset, including mid-transfer, takes effect on the next edge:
  - FSM returns to IDLE and the FIFO is emptied.
  - The in-flight read is discarded.
  - Any data from the aborted transfer never appears on the stream.
- Reset values: `busy` = 0, `done` = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `m_valid` = 0, `m_data` = 0, `m_last` = 0.

## Timing
- Cycle numbering: `start` is sampled at edge 0.
  - RUN begins at cycle 1, and the first `mem_en` is in cycle 1.
  - Data is written into the FIFO in cycle 2.
  - `m_valid` first goes high in cycle 3.
- Latency from `start` to the first beat: 3 cycles.
- Throughput with `m_ready` held at 1: one beat per cycle. The last beat of an N-word transfer occurs in cycle N+2, and `done` pulses in cycle N+3.
- Back-pressure: reads stall within 1 cycle of the FIFO reaching `FIFO_DEPTH` minus in-flight reads, and resume as soon as credit frees.
- `m_data` and `m_last` hold stable while `m_valid & !m_ready`.

## Configuration
- Macro: `OUTPUT_DRAIN_RELU_EN`.
- Defined: `m_data` is ReLU of the FIFO head, read as signed two's complement. Negative values become 0 and others pass unchanged. This is combinational on the output, with no added latency.
- Undefined: `m_data` is the raw stored word.

## Structure
- Shared package `matmul_pkg`:
  - default `DATA_WIDTH` and `ADDR_WIDTH` constants;
  - the `drain_state_t` enum (IDLE, RUN, FLUSH).
- Sub-module `drain_fifo`: a synchronous FIFO of `FIFO_DEPTH` entries with push/pop, an occupancy count, and a `last` flag stored per entry.
- Top level holds the FSM, address/issue counter, credit logic, beat counter and ReLU.

## Test plan
- Transfer at address 0:
  - Stimulus: memory holds 0x0001..0x0004 at 0..3; `base_addr` = 0, `len` = 4; `m_ready` = 1.
  - Response: beats 1, 2, 3, 4 in cycles 3..6; `m_last` only on 4; `done` in cycle 7; `busy` from cycle 1 to cycle 6.
- Back-pressure:
  - Stimulus: `len` = 16; `m_ready` pattern 1,0,0,1 repeating.
  - Response: all 16 words delivered in order, with none duplicated or lost. `mem_en` is never high when `occupancy + inflight` = 4, and `m_data` stays stable during stalls.
- Address wrap:
  - Stimulus: `base_addr` = 0xFFE, `len` = 4.
  - Response: `mem_addr` sequence 0xFFE, 0xFFF, 0x000, 0x001; data order matches.
- Zero length and busy:
  - Stimulus: `len` = 0; also a second `start` while `busy`.
  - Response: for `len` = 0, `done` pulses 1 cycle after `start` and `m_valid` stays 0. The second `start` during `busy` is ignored: the transfer count is unchanged.
- Reset mid-transfer:
  - Stimulus: `rst` after 5 beats of a 16-word transfer, then `base_addr` = 0x100, `len` = 2.
  - Response: all outputs at reset values the next cycle; only mem[0x100] and mem[0x101] appear afterwards.
- ReLU configuration:
  - Stimulus: memory holds 0x8001 and 0x7FFF.
  - Response: with `OUTPUT_DRAIN_RELU_EN` defined, 0x0000 then 0x7FFF. Without it, 0x8001 then 0x7FFF.
